// File: rtl/fifo_prog_v_pkg.sv
// fifo_pkg_v: shared constants and helpers for the programmable-threshold FIFO
package fifo_pkg_v;
  localparam int DATA_W_DEF = 24;
  localparam int DEPTH_DEF  = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Explicit wrap so non-power-of-2 depths never address past the last entry
  function automatic int ptr_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/fifo_prog_v_if.sv
// fifo_prog_v_if: producer/consumer bus of the FIFO, master drives requests
interface fifo_prog_v_if #(
  parameter int DATA_W = fifo_pkg_v::DATA_W_DEF,
  parameter int DEPTH  = fifo_pkg_v::DEPTH_DEF
);
  import fifo_pkg_v::*;
  localparam int ADDR_W = clog2(DEPTH);
  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W:0]   almst_e_thr;
  logic [ADDR_W:0]   almst_f_thr;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W:0]   data_count;
  logic              empty;
  logic              full;
  logic              almst_empty;
  logic              almst_full;
  logic              overflow;
  logic              underflow;
  logic              err;
  modport master (
    output data_in, wr_en, rd_en, almst_e_thr, almst_f_thr, err_clr,
    input  data_out, data_valid, data_count, empty, full, almst_empty, almst_full,
           overflow, underflow, err
  );
  modport slave (
    input  data_in, wr_en, rd_en, almst_e_thr, almst_f_thr, err_clr,
    output data_out, data_valid, data_count, empty, full, almst_empty, almst_full,
           overflow, underflow, err
  );
endinterface

// File: rtl/fifo_prog_v_ram.sv
// fifo_ram_v: storage array with synchronous write and asynchronous read
module fifo_ram_v #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_prog_v.sv
// fifo_prog_v: single-clock FIFO, any depth, programmable almost flags, optional FWFT
module fifo_prog_v
  import fifo_pkg_v::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter bit FWFT   = 1'b0
) (
  input logic          clk,
  input logic          reset,
  fifo_prog_v_if.slave bus
);
  localparam int ADDR_W = clog2(DEPTH);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data, dout_q, dout_d;
  logic empty_q, full_q, ae_q, af_q, ovf_q, udf_q, err_q, dv_q;
  logic empty_d, full_d, ae_d, af_d, ovf_d, udf_d, err_d, dv_d;
  logic wr_acc, rd_acc;
  fifo_ram_v #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );
  // Flags come from the next count so they always agree with data_count
  always_comb begin
    rd_acc   = bus.rd_en & ~empty_q;
    wr_acc   = bus.wr_en & (~full_q | rd_acc);
    wr_ptr_d = wr_acc ? ADDR_W'(ptr_inc(int'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ADDR_W'(ptr_inc(int'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(wr_acc) - CW'(rd_acc);
    empty_d  = cnt_d == '0;
    full_d   = cnt_d == FULL_CNT;
    ae_d     = cnt_d <= bus.almst_e_thr;
    af_d     = cnt_d >= bus.almst_f_thr;
    ovf_d    = bus.wr_en & ~wr_acc;
    udf_d    = bus.rd_en & ~rd_acc;
    err_d    = ovf_d | udf_d | (err_q & ~bus.err_clr);
    dv_d     = rd_acc;
    dout_d   = rd_acc ? rd_data : dout_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      err_q    <= 1'b0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      err_q    <= err_d;
      dv_q     <= dv_d;
      dout_q   <= dout_d;
    end
  end
  // FWFT exposes the head directly; it is forced to zero while nothing is stored
  assign bus.data_out    = FWFT ? (empty_q ? '0 : rd_data) : dout_q;
  assign bus.data_valid  = FWFT ? ~empty_q : dv_q;
  assign bus.data_count  = cnt_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almst_empty = ae_q;
  assign bus.almst_full  = af_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_fifo_prog_v.sv
// tb_fifo_prog_v: vector table plus scoreboard for standard and FWFT FIFO instances
module tb_fifo_prog_v;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fifo_prog_v_if #(.DATA_W(24), .DEPTH(5)) if0 ();
  fifo_prog_v_if #(.DATA_W(24), .DEPTH(5)) if1 ();
  fifo_prog_v #(.DATA_W(24), .DEPTH(5), .FWFT(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  fifo_prog_v #(.DATA_W(24), .DEPTH(5), .FWFT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  typedef struct {
    logic wr, rd, clr;
    logic [23:0] din;
    logic [3:0] et, ft;
    int cnt;
    logic e, f, ae, af, ov, ud, er;
  } vec_t;
  vec_t tv[$];
  int total = 0;
  int bad = 0;
  logic [23:0] mdl[$];
  logic [23:0] expq[$];
  logic [23:0] last = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cyc0(input logic wr, input logic rd, input logic clr, input logic [23:0] din);
    logic ra, wa;
    if0.wr_en = wr;
    if0.rd_en = rd;
    if0.err_clr = clr;
    if0.data_in = din;
    ra = rd && (mdl.size() > 0);
    wa = wr && ((mdl.size() < 5) || ra);
    if (ra) expq.push_back(mdl.pop_front());
    if (wa) mdl.push_back(din);
    tick();
    if0.wr_en = 1'b0;
    if0.rd_en = 1'b0;
    if0.err_clr = 1'b0;
    chk("count", 32'(if0.data_count), 32'(mdl.size()));
    if (expq.size() > 0) begin
      last = expq.pop_front();
      chk("dvalid", 32'(if0.data_valid), 32'd1);
      chk("dout", 32'(if0.data_out), 32'(last));
    end else begin
      chk("dvalid_lo", 32'(if0.data_valid), 32'd0);
      chk("dout_hold", 32'(if0.data_out), 32'(last));
    end
  endtask
  task automatic chk_reset0;
    chk("rst_count", 32'(if0.data_count), 32'd0);
    chk("rst_empty", 32'(if0.empty), 32'd1);
    chk("rst_full", 32'(if0.full), 32'd0);
    chk("rst_ae", 32'(if0.almst_empty), 32'd1);
    chk("rst_af", 32'(if0.almst_full), 32'd0);
    chk("rst_dout", 32'(if0.data_out), 32'd0);
    chk("rst_dv", 32'(if0.data_valid), 32'd0);
    chk("rst_ovf", 32'(if0.overflow), 32'd0);
    chk("rst_udf", 32'(if0.underflow), 32'd0);
    chk("rst_err", 32'(if0.err), 32'd0);
  endtask
  initial begin
    logic [23:0] d;
    if0.wr_en = 0; if0.rd_en = 0; if0.err_clr = 0; if0.data_in = '0;
    if0.almst_e_thr = 4'd1; if0.almst_f_thr = 4'd4;
    if1.wr_en = 0; if1.rd_en = 0; if1.err_clr = 0; if1.data_in = '0;
    if1.almst_e_thr = 4'd1; if1.almst_f_thr = 4'd4;
    tick();
    tick();
    reset = 1'b0;
    chk_reset0();
    chk("rst_empty1", 32'(if1.empty), 32'd1);
    chk("rst_dv1", 32'(if1.data_valid), 32'd0);
    //             wr rd clr din       et ft cnt e  f  ae af ov ud er
    tv.push_back('{1, 0, 0, 24'h11, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0});
    tv.push_back('{1, 0, 0, 24'h22, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{1, 0, 0, 24'h33, 1, 4, 3, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{1, 0, 0, 24'h44, 1, 4, 4, 0, 0, 0, 1, 0, 0, 0});
    tv.push_back('{1, 0, 0, 24'h55, 1, 4, 5, 0, 1, 0, 1, 0, 0, 0});
    tv.push_back('{1, 0, 0, 24'h66, 1, 4, 5, 0, 1, 0, 1, 1, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 4, 0, 0, 0, 1, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 3, 0, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 2, 0, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 1, 0, 0, 1, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 0, 1, 0, 1, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 0, 1, 0, 1, 0, 0, 1, 1});
    tv.push_back('{1, 1, 0, 24'h77, 1, 4, 1, 0, 0, 1, 0, 0, 1, 1});
    tv.push_back('{1, 0, 0, 24'h88, 1, 4, 2, 0, 0, 0, 0, 0, 0, 1});
    tv.push_back('{1, 0, 0, 24'h99, 1, 4, 3, 0, 0, 0, 0, 0, 0, 1});
    tv.push_back('{1, 0, 0, 24'hAA, 1, 4, 4, 0, 0, 0, 1, 0, 0, 1});
    tv.push_back('{1, 0, 0, 24'hBB, 1, 4, 5, 0, 1, 0, 1, 0, 0, 1});
    tv.push_back('{1, 1, 0, 24'hCC, 1, 4, 5, 0, 1, 0, 1, 0, 0, 1});
    tv.push_back('{1, 1, 0, 24'hDD, 1, 4, 5, 0, 1, 0, 1, 0, 0, 1});
    tv.push_back('{1, 1, 0, 24'hEE, 1, 4, 5, 0, 1, 0, 1, 0, 0, 1});
    tv.push_back('{0, 0, 1, 24'h0,  1, 4, 5, 0, 1, 0, 1, 0, 0, 0});
    tv.push_back('{1, 0, 1, 24'hFF, 1, 4, 5, 0, 1, 0, 1, 1, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 4, 0, 0, 0, 1, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 3, 0, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 2, 0, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 0, 0, 24'h0,  1, 2, 2, 0, 0, 0, 1, 0, 0, 1});
    tv.push_back('{0, 0, 0, 24'h0,  7, 4, 2, 0, 0, 1, 0, 0, 0, 1});
    tv.push_back('{0, 0, 0, 24'h0,  1, 0, 2, 0, 0, 0, 1, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 1, 0, 0, 1, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0, 24'h0,  1, 4, 0, 1, 0, 1, 0, 0, 0, 1});
    tv.push_back('{0, 0, 1, 24'h0,  1, 4, 0, 1, 0, 1, 0, 0, 0, 0});
    for (int i = 0; i < tv.size(); i++) begin
      if0.almst_e_thr = tv[i].et;
      if0.almst_f_thr = tv[i].ft;
      cyc0(tv[i].wr, tv[i].rd, tv[i].clr, tv[i].din);
      chk($sformatf("v%0d_cnt", i), 32'(if0.data_count), 32'(tv[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(if0.empty), 32'(tv[i].e));
      chk($sformatf("v%0d_full", i), 32'(if0.full), 32'(tv[i].f));
      chk($sformatf("v%0d_ae", i), 32'(if0.almst_empty), 32'(tv[i].ae));
      chk($sformatf("v%0d_af", i), 32'(if0.almst_full), 32'(tv[i].af));
      chk($sformatf("v%0d_ovf", i), 32'(if0.overflow), 32'(tv[i].ov));
      chk($sformatf("v%0d_udf", i), 32'(if0.underflow), 32'(tv[i].ud));
      chk($sformatf("v%0d_err", i), 32'(if0.err), 32'(tv[i].er));
    end
    if0.almst_e_thr = 4'd1;
    if0.almst_f_thr = 4'd4;
    d = 24'h100;
    for (int i = 0; i < 3; i++) begin cyc0(1, 0, 0, d); d++; end
    for (int i = 0; i < 3; i++) cyc0(0, 1, 0, '0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin cyc0(1, 0, 0, d); d++; end
      for (int i = 0; i < 4; i++) cyc0(0, 1, 0, '0);
    end
    chk("wrap_empty", 32'(if0.empty), 32'd1);
    cyc0(0, 1, 0, '0);
    chk("pre_udf", 32'(if0.underflow), 32'd1);
    cyc0(1, 0, 0, 24'hA1);
    cyc0(1, 0, 0, 24'hA2);
    cyc0(1, 0, 0, 24'hA3);
    cyc0(0, 1, 0, '0);
    cyc0(1, 0, 0, 24'hA4);
    chk("pre_err", 32'(if0.err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl.delete();
    expq.delete();
    last = '0;
    chk_reset0();
    cyc0(0, 1, 0, '0);
    chk("post_rst_udf", 32'(if0.underflow), 32'd1);
    chk("post_rst_err", 32'(if0.err), 32'd1);
    if1.wr_en = 1; if1.data_in = 24'hABCDEF;
    tick();
    if1.wr_en = 0;
    chk("fw_empty", 32'(if1.empty), 32'd0);
    chk("fw_dout", 32'(if1.data_out), 32'hABCDEF);
    chk("fw_dv", 32'(if1.data_valid), 32'd1);
    chk("fw_cnt", 32'(if1.data_count), 32'd1);
    tick();
    chk("fw_hold", 32'(if1.data_out), 32'hABCDEF);
    if1.rd_en = 1;
    tick();
    if1.rd_en = 0;
    chk("fw_pop_empty", 32'(if1.empty), 32'd1);
    chk("fw_pop_dv", 32'(if1.data_valid), 32'd0);
    chk("fw_pop_cnt", 32'(if1.data_count), 32'd0);
    if1.wr_en = 1; if1.rd_en = 1; if1.data_in = 24'h123456;
    tick();
    if1.wr_en = 0; if1.rd_en = 0;
    chk("fw_both_udf", 32'(if1.underflow), 32'd1);
    chk("fw_both_cnt", 32'(if1.data_count), 32'd1);
    chk("fw_both_dout", 32'(if1.data_out), 32'h123456);
    if1.wr_en = 1; if1.data_in = 24'h654321;
    tick();
    if1.wr_en = 0;
    chk("fw_head", 32'(if1.data_out), 32'h123456);
    chk("fw_cnt2", 32'(if1.data_count), 32'd2);
    if1.rd_en = 1;
    tick();
    chk("fw_next", 32'(if1.data_out), 32'h654321);
    tick();
    if1.rd_en = 0;
    chk("fw_drained", 32'(if1.empty), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
